// File: rtl/lmsm_pkg.sv
// Shared definitions for the load/store-multiple register-list sequencer.
// State encoding and register-list widths.
package lmsm_pkg;

  localparam int REGLIST_W = 8;
  localparam int REGIDX_W  = 3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SCAN  = 2'd1,
    S_ISSUE = 2'd2,
    S_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/lmsm_sequencer_if.sv
// Handshake bundle between control FSM / datapath and the LM/SM sequencer.
// master = control+datapath side, slave = sequencer.
interface lmsm_sequencer_if
  import lmsm_pkg::*;
#(
  parameter int ADDR_W = 16
);
  logic                 start;
  logic [REGLIST_W-1:0] mask;
  logic [ADDR_W-1:0]    base_addr;
  logic                 step;
  logic                 busy;
  logic                 valid;
  logic [REGIDX_W-1:0]  reg_idx;
  logic [ADDR_W-1:0]    mem_addr;
  logic                 done;

  modport master (
    output start, mask, base_addr, step,
    input  busy, valid, reg_idx, mem_addr, done
  );

  modport slave (
    input  start, mask, base_addr, step,
    output busy, valid, reg_idx, mem_addr, done
  );
endinterface

// File: rtl/lowest_set_8.sv
// Priority encoder: index of the lowest set bit of an 8-bit vector.
// o_any flags a non-zero input; o_idx is 0 when nothing is set.
module lowest_set_8
  import lmsm_pkg::*;
(
  input  logic [REGLIST_W-1:0] i_vec,
  output logic [REGIDX_W-1:0]  o_idx,
  output logic                 o_any
);

  // Scan from the top so the lowest set bit is the last writer.
  always_comb begin
    o_idx = '0;
    for (int i = REGLIST_W - 1; i >= 0; i--) begin
      if (i_vec[i]) o_idx = REGIDX_W'(i);
    end
  end

  assign o_any = |i_vec;

endmodule

// File: rtl/lmsm_sequencer.sv
// Register-list sequencer for LM/SM: walks the set bits of the mask
// in ascending order, issuing one (reg, addr) pair per accepted step.
module lmsm_sequencer
  import lmsm_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int ADDR_INC = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  lmsm_sequencer_if.slave   bus
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [REGLIST_W-1:0] r_pending;
  logic [REGLIST_W-1:0] w_pending_nxt;
  logic [REGLIST_W-1:0] w_remain;
  logic [ADDR_W-1:0]    r_addr;
  logic [ADDR_W-1:0]    w_addr_nxt;
  logic [REGIDX_W-1:0]  w_idx;
  logic                 w_any;

  lowest_set_8 u_enc (
    .i_vec (r_pending),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  // Clearing the lowest set bit: x & (x-1).
  assign w_remain = r_pending & (r_pending - REGLIST_W'(1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= S_IDLE;
      r_pending <= '0;
      r_addr    <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pending <= w_pending_nxt;
      r_addr    <= w_addr_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_pending_nxt = r_pending;
    w_addr_nxt    = r_addr;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_nxt   = S_SCAN;
          w_pending_nxt = bus.mask;
          w_addr_nxt    = bus.base_addr;
        end
      end
      S_SCAN: begin
        w_state_nxt = w_any ? S_ISSUE : S_DONE;
      end
      S_ISSUE: begin
        if (bus.step) begin
          w_pending_nxt = w_remain;
          w_addr_nxt    = r_addr + ADDR_W'(ADDR_INC);
          w_state_nxt   = (w_remain != '0) ? S_ISSUE : S_DONE;
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign bus.busy     = (r_state != S_IDLE);
  assign bus.valid    = (r_state == S_ISSUE);
  assign bus.done     = (r_state == S_DONE);
  assign bus.reg_idx  = w_idx;
  assign bus.mem_addr = r_addr;

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed + randomized bench for lmsm_sequencer against a
// transfer-list model built from the mask and base address.
module tb_lmsm_sequencer;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  lmsm_sequencer_if #(.ADDR_W(16)) bus ();

  lmsm_sequencer #(.ADDR_W(16), .ADDR_INC(1)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic b, input logic v,
                         input logic d);
    chk({tag, ".busy"},  32'(bus.busy),  32'(b));
    chk({tag, ".valid"}, 32'(bus.valid), 32'(v));
    chk({tag, ".done"},  32'(bus.done),  32'(d));
  endtask

  function automatic logic pick_step(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return cyc[0];
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  // Model: the ordered transfer list is every set mask bit, ascending,
  // with consecutive addresses starting at base (16-bit wrap).
  // Drives are made on negedges; outputs are sampled on negedges.
  task automatic run_seq(input string tag, input logic [7:0] m,
                         input logic [15:0] b, input int mode,
                         input bit restart);
    int          exp_idx[8];
    logic [15:0] exp_addr[8];
    int          n;
    int          k;
    int          cyc;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      if (m[i]) begin
        exp_idx[n]  = i;
        exp_addr[n] = b + 16'(n);
        n++;
      end
    end
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mask      = m;
    bus.base_addr = b;
    @(negedge clk);
    bus.start = 1'b0;
    bus.mask  = $urandom();
    chk_ctl({tag, ".scan"}, 1'b1, 1'b0, 1'b0);
    bus.step = pick_step(mode, 0);
    @(negedge clk);
    k   = 0;
    cyc = 0;
    while (k < n && cyc < 200) begin
      chk_ctl({tag, ".xfer"}, 1'b1, 1'b1, 1'b0);
      chk({tag, ".idx"},  32'(bus.reg_idx),  32'(exp_idx[k]));
      chk({tag, ".addr"}, 32'(bus.mem_addr), 32'(exp_addr[k]));
      bus.start = 1'b0;
      if (restart && cyc == 1) begin
        bus.start     = 1'b1;
        bus.mask      = 8'h0F;
        bus.base_addr = ~b;
      end
      bus.step = pick_step(mode, cyc);
      @(negedge clk);
      if (bus.step) k++;
      cyc++;
    end
    if (k < n) chk({tag, ".timeout"}, 32'(k), 32'(n));
    bus.start = 1'b0;
    bus.step  = 1'b0;
    chk_ctl({tag, ".done"}, 1'b1, 1'b0, 1'b1);
    @(negedge clk);
    chk_ctl({tag, ".after"}, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] b;
    n_cmp         = 0;
    n_bad         = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mask      = '0;
    bus.base_addr = '0;
    bus.step      = 1'b0;
    #1;
    chk_ctl("reset", 1'b0, 1'b0, 1'b0);
    chk("reset.idx",  32'(bus.reg_idx),  32'd0);
    chk("reset.addr", 32'(bus.mem_addr), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run_seq("T1", 8'hA5, 16'h0040, 0, 1'b0);
    run_seq("T2", 8'h00, 16'h1234, 0, 1'b0);
    run_seq("T3", 8'hFF, 16'hFFFE, 1, 1'b0);
    run_seq("T4", 8'h81, 16'h0200, 1, 1'b1);

    // T5: abort mid-sequence with async reset
    b = 16'($urandom());
    @(negedge clk);
    bus.start     = 1'b1;
    bus.mask      = 8'h3C;
    bus.base_addr = b;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    chk("T5.idx0",  32'(bus.reg_idx),  32'd2);
    chk("T5.addr0", 32'(bus.mem_addr), 32'(b));
    bus.step = 1'b1;
    @(negedge clk);
    bus.step = 1'b0;
    chk("T5.idx1",  32'(bus.reg_idx),  32'd3);
    chk("T5.addr1", 32'(bus.mem_addr), 32'(16'(b + 16'd1)));
    rst_n = 1'b0;
    #1;
    chk_ctl("T5.rst", 1'b0, 1'b0, 1'b0);
    chk("T5.rst.idx",  32'(bus.reg_idx),  32'd0);
    chk("T5.rst.addr", 32'(bus.mem_addr), 32'd0);
    @(negedge clk);
    chk_ctl("T5.hold", 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk_ctl("T5.idle", 1'b0, 1'b0, 1'b0);
    run_seq("T5b", 8'h02, b, 0, 1'b0);

    // T6: step in IDLE is ignored
    bus.step = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk_ctl("T6.idle", 1'b0, 1'b0, 1'b0);
    end
    run_seq("T6", 8'h10, 16'h0777, 0, 1'b0);

    for (int t = 0; t < 12; t++) begin
      run_seq("RND", 8'($urandom()), 16'($urandom()),
              int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
